// File: rtl/neosd_dat_shifter.sv
// SD DAT-line shift engine: parallel word <-> 1/4/8 serial lanes with word-completion
// pulse and an independent CRC16-CCITT per lane, advanced on the SD clock strobe.
module neosd_dat_shifter #(
    parameter int WORD_W = 32,
    parameter int LANES  = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clkstrb_i,
    input  logic [1:0]            mode_i,
    input  logic                  dir_i,
    input  logic                  load_p_i,
    input  logic [WORD_W-1:0]     data_p_i,
    output logic [WORD_W-1:0]     data_p_o,
    input  logic                  shift_i,
    input  logic [LANES-1:0]      dat_i,
    output logic [LANES-1:0]      dat_o,
    input  logic                  crc_clr_i,
    output logic                  word_done_o,
    output logic [16*LANES-1:0]   crc_o
);

    localparam int CW = $clog2(WORD_W);

    logic [1:0]        r_mode;
    logic [WORD_W-1:0] r_data;
    logic [CW-1:0]     r_cnt;
    logic              r_done;
    logic [15:0]       r_crc [LANES];

    logic [3:0]        w_k;
    logic [CW-1:0]     w_last_cnt;
    logic              w_sh;
    logic [7:0]        w_din;
    logic [7:0]        w_dout;
    logic [7:0]        w_kmask;
    logic [WORD_W-1:0] w_shifted;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    // Effective lane count, clamped to the lanes actually built.
    always_comb begin
        w_k = 4'd1;
        case (r_mode)
            2'b01: begin
                if (LANES >= 4) w_k = 4'd4;
                else            w_k = 4'd1;
            end
            2'b10: begin
                if (LANES >= 8)      w_k = 4'd8;
                else if (LANES >= 4) w_k = 4'd4;
                else                 w_k = 4'd1;
            end
            default: w_k = 4'd1;
        endcase
    end

    // Final counter value of a word for the current width.
    always_comb begin
        w_last_cnt = CW'(WORD_W - 1);
        case (w_k)
            4'd4:    w_last_cnt = CW'(WORD_W / 4 - 1);
            4'd8:    w_last_cnt = CW'(WORD_W / 8 - 1);
            default: w_last_cnt = CW'(WORD_W - 1);
        endcase
    end

    // Widen the input lanes to 8 so all widths share one shift path.
    always_comb begin
        w_din             = 8'h00;
        w_din[LANES-1:0]  = dat_i;
    end

    assign w_sh      = clkstrb_i & shift_i & ~load_p_i;
    assign w_kmask   = 8'((9'd1 << w_k) - 9'd1);
    assign w_shifted = (r_data << w_k) | WORD_W'(w_din & w_kmask);
    // Top k bits land on lanes k-1..0, so the highest active lane carries the MSB.
    assign w_dout    = r_data[WORD_W-1 -: 8] >> (4'd8 - w_k);

    assign dat_o       = w_dout[LANES-1:0];
    assign data_p_o    = r_data;
    assign word_done_o = r_done;

    for (genvar g = 0; g < LANES; g++) begin : g_crc_out
        assign crc_o[16*g +: 16] = r_crc[g];
    end

    // Bus-width register, only captured at load or CRC clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mode <= 2'b00;
        end else if (load_p_i || crc_clr_i) begin
            r_mode <= mode_i;
        end
    end

    // Shift register, shift counter and word-done pulse.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_data <= {WORD_W{1'b0}};
            r_cnt  <= {CW{1'b0}};
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load_p_i) begin
                r_data <= data_p_i;
                r_cnt  <= {CW{1'b0}};
            end else if (w_sh) begin
                r_data <= w_shifted;
                if (r_cnt == w_last_cnt) begin
                    r_cnt  <= {CW{1'b0}};
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    // Per-lane CRC; TX uses the pre-shift output bit, RX the sampled input bit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int j = 0; j < LANES; j++) r_crc[j] <= 16'h0000;
        end else if (crc_clr_i) begin
            for (int j = 0; j < LANES; j++) r_crc[j] <= 16'h0000;
        end else if (w_sh) begin
            for (int j = 0; j < LANES; j++) begin
                if (4'(j) < w_k) begin
                    r_crc[j] <= crc16_step(r_crc[j], dir_i ? w_dout[j] : w_din[j]);
                end
            end
        end
    end

endmodule

// File: tb/tb_neosd_dat_shifter.sv
// Directed self-checking bench for neosd_dat_shifter (8-lane instance plus a 4-lane
// instance sharing stimulus to cover width clamping).
module tb_neosd_dat_shifter;

    logic         clk = 1'b0;
    logic         rstn;
    logic         clkstrb, shift, load, crc_clr, dir;
    logic [1:0]   mode;
    logic [31:0]  data_in;
    logic [7:0]   dat_i;
    logic [31:0]  data_out, data4;
    logic [7:0]   dat_o;
    logic [3:0]   dat_o4;
    logic         done, done4;
    logic [127:0] crc;
    logic [63:0]  crc4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    neosd_dat_shifter #(.WORD_W(32), .LANES(8)) u_dut (
        .clk_i(clk), .rstn_i(rstn), .clkstrb_i(clkstrb), .mode_i(mode), .dir_i(dir),
        .load_p_i(load), .data_p_i(data_in), .data_p_o(data_out), .shift_i(shift),
        .dat_i(dat_i), .dat_o(dat_o), .crc_clr_i(crc_clr), .word_done_o(done), .crc_o(crc)
    );

    neosd_dat_shifter #(.WORD_W(32), .LANES(4)) u_dut4 (
        .clk_i(clk), .rstn_i(rstn), .clkstrb_i(clkstrb), .mode_i(mode), .dir_i(dir),
        .load_p_i(load), .data_p_i(data_in), .data_p_o(data4), .shift_i(shift),
        .dat_i(dat_i[3:0]), .dat_o(dat_o4), .crc_clr_i(crc_clr), .word_done_o(done4), .crc_o(crc4)
    );

    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        crc_ref = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic sh, input logic ld, input logic clr);
        clkstrb = s; shift = sh; load = ld; crc_clr = clr;
        @(posedge clk);
        #1;
        clkstrb = 1'b0; shift = 1'b0; load = 1'b0; crc_clr = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        logic [15:0] ec;
        logic [15:0] ecl [8];
        logic [7:0]  nb;

        rstn = 1'b0; clkstrb = 1'b0; shift = 1'b0; load = 1'b0; crc_clr = 1'b0;
        dir = 1'b0; mode = 2'b00; data_in = 32'h0; dat_i = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", data_out, 128'h0);
        chk("rst_dat_o", dat_o, 128'h0);
        chk("rst_done", done, 128'h0);
        chk("rst_crc", crc, 128'h0);
        rstn = 1'b1;

        // 1-bit transmit of 0xA5C30F01
        mode = 2'b00; dir = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        w = 32'hA5C3_0F01; data_in = w;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("tx1_load", data_out, w);
        ec = 16'h0000;
        for (int i = 0; i < 32; i++) begin
            chk("tx1_dat_o", dat_o, {7'b0, w[31-i]});
            ec = crc_ref(ec, w[31-i]);
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            chk("tx1_done", done, (i == 31) ? 128'h1 : 128'h0);
        end
        chk("tx1_crc0", crc[15:0], ec);
        chk("tx1_crc_hi", crc[127:16], 128'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("tx1_done_once", done, 128'h0);

        // 512 bytes of 0xFF on one lane
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        data_in = 32'hFFFF_FFFF;
        for (int k = 0; k < 128; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            repeat (32) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("crc_ref_7fa1", crc[15:0], 16'h7FA1);

        // 4-bit receive of nibbles 1..8
        mode = 2'b01; dir = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 8; j++) ecl[j] = 16'h0000;
        for (int n = 1; n <= 8; n++) begin
            nb = 8'(n);
            dat_i = nb;
            for (int j = 0; j < 4; j++) ecl[j] = crc_ref(ecl[j], nb[j]);
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            chk("rx4_done", done, (n == 8) ? 128'h1 : 128'h0);
        end
        chk("rx4_word", data_out, 32'h1234_5678);
        for (int j = 0; j < 8; j++) chk("rx4_crc_lane", crc[16*j +: 16], ecl[j]);
        dat_i = 8'h09;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rx4_next_word", data_out, 32'h2345_6789);
        chk("rx4_next_done", done, 128'h0);

        // 8-bit transmit; the 4-lane instance clamps to 4-bit
        mode = 2'b10; dir = 1'b1; dat_i = 8'h00;
        w = 32'hDEAD_BEEF; data_in = w;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int s = 0; s < 8; s++) begin
            chk("tx8_dat_o", dat_o, (s < 4) ? {120'h0, w[31-8*s -: 8]} : 128'h0);
            chk("tx8_l4_dat_o", dat_o4, {124'h0, w[31-4*s -: 4]});
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            chk("tx8_done", done, (s == 3 || s == 7) ? 128'h1 : 128'h0);
            chk("tx8_l4_done", done4, (s == 7) ? 128'h1 : 128'h0);
        end

        // Collisions
        mode = 2'b00; dir = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        data_in = 32'hF000_0000;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("col_crc_pre", crc[15:0], 16'h1021);
        data_in = 32'h1234_5678;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("col_load_data", data_out, 32'h1234_5678);
        chk("col_load_crc", crc, {112'h0, 16'h1021});
        chk("col_load_done", done, 128'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("col_clr_crc", crc, 128'h0);
        chk("col_clr_data", data_out, 32'h2468_ACF0);
        mode = 2'b10;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("col_mode_data", data_out, 32'h48D1_59E0);
        chk("col_mode_dat_o", dat_o, 128'h0);
        mode = 2'b00;

        // Reset mid-word
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        w = 32'hA5C3_0F01; data_in = w;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        rstn = 1'b0;
        mode = 2'b10;
        #2;
        chk("rstmid_data", data_out, 128'h0);
        chk("rstmid_dat_o", dat_o, 128'h0);
        chk("rstmid_done", done, 128'h0);
        chk("rstmid_crc", crc, 128'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstmid_no_pulse", done, 128'h0);
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            chk("rstmid_cnt_done", done, (i == 31) ? 128'h1 : 128'h0);
        end
        mode = 2'b00;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rstmid_reload_dat_o", dat_o, {7'b0, w[31]});
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            chk("rstmid_reload_done", done, (i == 31) ? 128'h1 : 128'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
